// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU: IDLE -> EXEC -> HOLD per operation.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie; otherwise ties are round-robin.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic              grant_fire;
    logic              grant_id;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [2:0]        sel_op;

    logic [DATA_W-1:0] opa_reg;
    logic [DATA_W-1:0] opb_reg;
    logic [2:0]        opcode_reg;
    logic              opid_reg;

    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_result_reg;
    logic              rsp_zero_reg;
    logic              rsp_id_reg;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Holds the id of the most recent grant; resets to 1 so requester 0 wins the first tie.
    logic              last_grant_reg;
`endif

    assign req_valid = {req1_valid, req0_valid};

    // Grant selection: only IDLE can accept, and a lone requester always wins.
    always_comb begin
        grant_fire = (state_reg == IDLE) && (req_valid != 2'b00);
        grant_id   = req_valid[1];
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_grant_reg;
`endif
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = grant_fire && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    assign sel_a  = grant_id ? req1_a  : req0_a;
    assign sel_b  = grant_id ? req1_b  : req0_b;
    assign sel_op = grant_id ? req1_op : req0_op;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant_fire) state_next = EXEC;
            EXEC: state_next = HOLD;
            HOLD: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand registers feed the ALU directly; requester inputs never bypass them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_reg    <= '0;
            opb_reg    <= '0;
            opcode_reg <= '0;
            opid_reg   <= 1'b0;
        end else if (grant_fire) begin
            opa_reg    <= sel_a;
            opb_reg    <= sel_b;
            opcode_reg <= sel_op;
            opid_reg   <= grant_id;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (grant_fire) begin
            last_grant_reg <= grant_id;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_id_reg     <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_result_reg <= alu_res;
            rsp_zero_reg   <= alu_zero;
            rsp_id_reg     <= opid_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_valid_reg <= 1'b1;
        end else if ((state_reg == HOLD) && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign alu_a      = opa_reg;
    assign alu_b      = opb_reg;
    assign alu_op     = opcode_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_zero   = rsp_zero_reg;
    assign rsp_id     = rsp_id_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, directed corner sequences, and a randomized scoreboard run.
module tb_alu_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]    req0_op = '0, req1_op = '0;
    logic [DW-1:0] alu_a, alu_b, alu_res;
    logic [2:0]    alu_op;
    logic          alu_zero;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero, rsp_id;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_id(rsp_id)
    );

    // Opcode semantics of the shared ALU; 101 selects 1 when a < b (unsigned).
    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return (a < b) ? 32'd1 : 32'd0;
            3'b110:  return a * b;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_res  = alu_ref(alu_a, alu_b, alu_op);
        alu_zero = (alu_res == '0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts edges until rsp_valid is seen (sampled #1 after each edge); -1 on timeout.
    task automatic wait_rsp(output int edges);
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                edges = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]    vld;
        logic [DW-1:0] a0, b0, a1, b1;
        logic [2:0]    op0, op1;
        logic          exp_id;
        logic [DW-1:0] exp_res;
        logic          exp_zero;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int k);
        int n;
        @(posedge clk);
        #1;
        req0_a = vecs[k].a0; req0_b = vecs[k].b0; req0_op = vecs[k].op0;
        req1_a = vecs[k].a1; req1_b = vecs[k].b1; req1_op = vecs[k].op1;
        req0_valid = vecs[k].vld[0];
        req1_valid = vecs[k].vld[1];
        rsp_ready  = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d ready0", k), 32'(req0_ready), 32'(vecs[k].exp_id == 1'b0));
        check($sformatf("vec%0d ready1", k), 32'(req1_ready), 32'(vecs[k].exp_id == 1'b1));
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom);
        check($sformatf("vec%0d alu_a", k), alu_a, vecs[k].exp_id ? vecs[k].a1 : vecs[k].a0);
        check($sformatf("vec%0d alu_op", k), 32'(alu_op),
              32'(vecs[k].exp_id ? vecs[k].op1 : vecs[k].op0));
        wait_rsp(n);
        check($sformatf("vec%0d latency", k), n, 1);
        check($sformatf("vec%0d result", k), rsp_result, vecs[k].exp_res);
        check($sformatf("vec%0d zero", k), 32'(rsp_zero), 32'(vecs[k].exp_zero));
        check($sformatf("vec%0d id", k), 32'(rsp_id), 32'(vecs[k].exp_id));
        $display("[TB] vec %0d: id=%0d result=0x%0h zero=%0d", k, rsp_id, rsp_result, rsp_zero);
        @(posedge clk);
        #1;
        check($sformatf("vec%0d valid drop", k), 32'(rsp_valid), 0);
    endtask

    typedef struct {
        logic          id;
        logic [DW-1:0] res;
    } exp_t;

    initial begin
        int            n;
        int            gcyc, last_gcyc;
        logic          gid;
        exp_t          sbq[$];
        logic          pend[2];
        logic [DW-1:0] pa[2], pb[2];
        logic [2:0]    pop[2];
        logic          hs[2];
        logic          model_last;
        logic          exp_gid;
        logic          hold_prev;
        logic [DW-1:0] prev_res;
        logic          prev_zero, prev_id;
        int            grants;

        vecs[0] = '{2'b01, 32'd5, 32'd7, 32'd0, 32'd0, 3'b000, 3'b000, 1'b0, 32'd12, 1'b0};
        vecs[1] = '{2'b10, 32'd0, 32'd0, 32'd9, 32'd9, 3'b000, 3'b001, 1'b1, 32'd0, 1'b1};
        vecs[2] = '{2'b01, 32'd1, 32'd1, 32'd0, 32'd0, 3'b111, 3'b000, 1'b0, 32'd0, 1'b1};
        vecs[3] = '{2'b10, 32'd0, 32'd0, 32'hF0F0, 32'h0FF0, 3'b000, 3'b010, 1'b1, 32'h00F0, 1'b0};
        vecs[4] = '{2'b01, 32'h100, 32'h011, 32'd0, 32'd0, 3'b011, 3'b000, 1'b0, 32'h111, 1'b0};
        vecs[5] = '{2'b10, 32'd0, 32'd0, 32'd6, 32'd7, 3'b000, 3'b110, 1'b1, 32'd42, 1'b0};
        vecs[6] = '{2'b01, 32'd3, 32'd8, 32'd0, 32'd0, 3'b101, 3'b000, 1'b0, 32'd1, 1'b0};
        vecs[7] = '{2'b10, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 3'b000, 3'b000, 1'b1, 32'd0, 1'b1};

        // Reset state, sampled while reset is held.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst rsp_valid", 32'(rsp_valid), 0);
        check("rst rsp_result", rsp_result, 0);
        check("rst rsp_zero/id", {30'd0, rsp_zero, rsp_id}, 0);
        check("rst alu_a", alu_a, 0);
        check("rst alu_b", alu_b, 0);
        check("rst alu_op", 32'(alu_op), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) run_vec(k);

        // Round-robin on a continuous tie, with the issue interval.
        do_reset();
        @(posedge clk);
        #1;
        req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b000;
        req1_a = 32'd3; req1_b = 32'd4; req1_op = 3'b000;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        gcyc = 0;
        last_gcyc = 0;
        for (int g = 0; g < 4; g++) begin
            gid = 1'b0;
            n = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                gcyc++;
                if (req0_ready || req1_ready) begin
                    gid = req1_ready;
                    n = 1;
                    break;
                end
            end
            check($sformatf("rr grant%0d seen", g), n, 1);
`ifdef ALU_ARB_FIXED_PRIO_EN
            check($sformatf("rr grant%0d id", g), 32'(gid), 0);
`else
            check($sformatf("rr grant%0d id", g), 32'(gid), 32'(g % 2));
`endif
            if (g > 0) check($sformatf("rr interval%0d", g), gcyc - last_gcyc, 3);
            $display("[TB] tie grant %0d -> requester %0d at cycle %0d", g, gid, gcyc);
            last_gcyc = gcyc;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(posedge clk);

        // Backpressure: response held for 5 cycles, queued requester waits.
        do_reset();
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b000; req0_valid = 1'b1;
        @(negedge clk);
        check("bp ready0", 32'(req0_ready), 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_a = 32'd1; req1_b = 32'd2; req1_op = 3'b000; req1_valid = 1'b1;
        wait_rsp(n);
        check("bp latency", n, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d result", c), rsp_result, 32'd30);
            check($sformatf("bp hold%0d valid", c), 32'(rsp_valid), 1);
            check($sformatf("bp hold%0d no ready", c), {30'd0, req1_ready, req0_ready}, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp release valid", 32'(rsp_valid), 1);
        @(posedge clk);
        #1;
        check("bp valid drop", 32'(rsp_valid), 0);
        @(negedge clk);
        check("bp queued ready1", 32'(req1_ready), 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_rsp(n);
        check("bp second result", rsp_result, 32'd3);
        check("bp second id", 32'(rsp_id), 1);
        $display("[TB] backpressure: second response id=%0d result=%0d", rsp_id, rsp_result);
        @(posedge clk);

        // Reset during EXEC discards the operation.
        @(posedge clk);
        #1;
        req0_a = 32'd3; req0_b = 32'd4; req0_op = 3'b110; req0_valid = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        check("rx exec alu_op", 32'(alu_op), 32'(3'b110));
        rst_n = 1'b0;
        #1;
        check("rx alu_a", alu_a, 0);
        check("rx alu_b", alu_b, 0);
        check("rx alu_op", 32'(alu_op), 0);
        check("rx rsp", {29'd0, rsp_valid, rsp_zero, rsp_id}, 0);
        check("rx rsp_result", rsp_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("rx no response", n, 0);
        $display("[TB] reset in EXEC: responses after release=%0d", n);

        // Valid pulse that ends before any edge yields no transaction.
        @(posedge clk);
        #1;
        req0_a = 32'd8; req0_b = 32'd8; req0_op = 3'b000; req0_valid = 1'b1;
        #2;
        req0_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("glitch no response", n, 0);

        // Randomized run against the scoreboard.
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        hs[0] = 1'b0; hs[1] = 1'b0;
        model_last = 1'b1;
        hold_prev = 1'b0;
        prev_res = '0; prev_zero = 1'b0; prev_id = 1'b0;
        grants = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (hs[i]) pend[i] = 1'b0;
                if (!pend[i] && cyc < 600 && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    pa[i] = ($urandom_range(0, 3) == 0) ? 32'(i + 4) : $urandom;
                    pb[i] = ($urandom_range(0, 3) == 0) ? 32'(i + 4) : $urandom;
                    pop[i] = 3'($urandom);
                end
            end
            req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
            req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
            rsp_ready = (cyc >= 600) || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs[0] = req0_ready;
            hs[1] = req1_ready;
            if (req0_ready || req1_ready) begin
                check("rnd one grant", 32'(req0_ready && req1_ready), 0);
                check("rnd ready needs valid",
                      32'((req0_ready && !req0_valid) || (req1_ready && !req1_valid)), 0);
                check("rnd nothing in flight", sbq.size(), 0);
                if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    exp_gid = 1'b0;
`else
                    exp_gid = ~model_last;
`endif
                    check("rnd tie winner", 32'(req1_ready), 32'(exp_gid));
                end
                gid = req1_ready;
                sbq.push_back('{gid, alu_ref(pa[gid], pb[gid], pop[gid])});
                model_last = gid;
                grants++;
            end
            if (hold_prev) begin
                check("rnd held valid", 32'(rsp_valid), 1);
                check("rnd held result", rsp_result, prev_res);
                check("rnd held flags", {30'd0, rsp_zero, rsp_id}, {30'd0, prev_zero, prev_id});
            end
            if (rsp_valid) begin
                check("rnd ready while rsp", {30'd0, req1_ready, req0_ready}, 0);
                if (sbq.size() == 0) begin
                    fails++;
                    tests++;
                    $display("FAIL rnd unexpected response: got id %0d, expected none", rsp_id);
                end else if (!hold_prev) begin
                    check("rnd rsp id", 32'(rsp_id), 32'(sbq[0].id));
                    check("rnd rsp result", rsp_result, sbq[0].res);
                    check("rnd rsp zero", 32'(rsp_zero), 32'(sbq[0].res == '0));
                    $display("[TB] rnd txn %0d: id=%0d result=0x%0h", grants, rsp_id, rsp_result);
                end
                if (rsp_ready && sbq.size() != 0) void'(sbq.pop_front());
            end
            hold_prev = rsp_valid && !rsp_ready;
            prev_res = rsp_result; prev_zero = rsp_zero; prev_id = rsp_id;
        end
        check("rnd drained", sbq.size(), 0);
        check("rnd no stuck requests", {30'd0, pend[1] && !hs[1], pend[0] && !hs[0]}, 0);
        check("rnd activity", 32'(grants > 50), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
